// File: rtl/ram_scan_pkg.sv
// Shared types and constants for the RAM scan controller and its lab tops.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    SCAN = 2'b10
  } state_e;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_CLEAR  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered, read-old output.
// The array itself is never reset; only the output register is.
module ram_sp #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register: samples the pre-write contents, so same-address reads return old data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_scan_controller.sv
// Manual RAM access plus auto clear/fill walks and a dwell-timed display scan.
module ram_scan_controller
  import ram_scan_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int DWELL  = 25_000_000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wren,
  input  logic [1:0]        mode,
  input  logic              go,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CW-1:0]     dwell_q, dwell_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              go_q;
  logic              go_rise_s;

  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_re_s;

  assign go_rise_s = go & ~go_q;

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      dwell_q    <= '0;
      fill_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      dwell_q    <= dwell_d;
      fill_q     <= fill_d;
      done_q     <= done_d;
      busy_q     <= (state_d != IDLE);
      go_q       <= go;
    end
  end

  // Next-state logic and RAM port steering
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    dwell_d     = dwell_q;
    fill_d      = fill_q;
    done_d      = 1'b0;
    ram_addr_s  = address_in;
    ram_we_s    = 1'b0;
    ram_wdata_s = data_in;
    ram_re_s    = 1'b0;
    case (state_q)
      IDLE: begin
        cur_addr_d = address_in;
        ram_we_s   = wren;
        ram_re_s   = 1'b1;
        if (go_rise_s) begin
          case (mode)
            MODE_CLEAR, MODE_FILL: begin
              fill_d     = (mode == MODE_FILL) ? data_in : '0;
              cur_addr_d = '0;
              state_d    = WALK;
            end
            MODE_SCAN: begin
              cur_addr_d = '0;
              dwell_d    = '0;
              state_d    = SCAN;
            end
            MODE_MANUAL: begin
              state_d = IDLE;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        ram_addr_s  = cur_addr_q;
        ram_we_s    = 1'b1;
        ram_wdata_s = fill_q;
        cur_addr_d  = cur_addr_q + ADDR_W'(1);
        if (cur_addr_q == ADDR_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WALK;
        end
      end
      SCAN: begin
        ram_addr_s = cur_addr_q;
        ram_re_s   = 1'b1;
        if (dwell_q == DWELL_LAST) begin
          dwell_d    = '0;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
        end else begin
          dwell_d = dwell_q + CW'(1);
        end
        if (go_rise_s) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A manual-mode wren held through reset must not reach the array
  ram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock (clock),
    .resetn(resetn),
    .addr  (ram_addr_s),
    .we    (ram_we_s & resetn),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .rdata (q)
  );

  assign cur_addr = cur_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram_scan_controller.sv
// Directed bench for ram_scan_controller with a cycle-level behavioural model.
module tb_ram_scan_controller;
  localparam int DW    = 4;
  localparam int AW    = 5;
  localparam int DWELL = 4;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          resetn, wren, go;
  logic [AW-1:0] address_in;
  logic [DW-1:0] data_in;
  logic [1:0]    mode;
  logic [DW-1:0] q;
  logic [AW-1:0] cur_addr;
  logic          busy, done;

  int total = 0;
  int bad   = 0;

  ram_scan_controller #(.DATA_W(DW), .ADDR_W(AW), .DWELL(DWELL)) dut (
    .clock(clock), .resetn(resetn), .address_in(address_in), .data_in(data_in),
    .wren(wren), .mode(mode), .go(go), .q(q), .cur_addr(cur_addr),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: memory array plus abstract progress (words left to walk, ticks since scan start)
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_walk_left = 0;
  int            m_tick = 0;
  int            m_addr = 0;
  bit            m_scan = 1'b0;
  bit            m_go_prev = 1'b0;
  bit            m_done = 1'b0;
  bit            m_q_known = 1'b0;
  logic [DW-1:0] m_q = '0;
  logic [DW-1:0] m_fill = '0;

  always @(posedge clock) begin
    bit rise;
    int idx;
    if (!resetn) begin
      m_walk_left = 0; m_scan = 1'b0; m_tick = 0; m_go_prev = 1'b0;
      m_done = 1'b0; m_q = '0; m_q_known = 1'b1; m_addr = 0;
    end else begin
      rise = go && !m_go_prev;
      m_go_prev = go;
      m_done = 1'b0;
      if (m_walk_left > 0) begin
        idx = DEPTH - m_walk_left;
        m_mem[idx] = m_fill;
        m_known[idx] = 1'b1;
        m_walk_left--;
        m_addr = (idx + 1) % DEPTH;
        if (m_walk_left == 0) m_done = 1'b1;
      end else if (m_scan) begin
        idx = (m_tick / DWELL) % DEPTH;
        m_q = m_mem[idx];
        m_q_known = m_known[idx];
        m_tick++;
        m_addr = (m_tick / DWELL) % DEPTH;
        if (rise) m_scan = 1'b0;
      end else begin
        idx = int'(address_in);
        m_q = m_mem[idx];
        m_q_known = m_known[idx];
        if (wren) begin
          m_mem[idx] = data_in;
          m_known[idx] = 1'b1;
        end
        m_addr = idx;
        if (rise && (mode == 2'b01 || mode == 2'b11)) begin
          m_fill = (mode == 2'b11) ? data_in : 4'h0;
          m_walk_left = DEPTH;
          m_addr = 0;
        end else if (rise && mode == 2'b10) begin
          m_scan = 1'b1;
          m_tick = 0;
          m_addr = 0;
        end
      end
    end
    #1;
    chk("model_cur_addr", 32'(cur_addr), 32'(m_addr));
    chk("model_busy", 32'(busy), 32'((m_walk_left > 0) || m_scan));
    chk("model_done", 32'(done), 32'(m_done));
    if (m_q_known) chk("model_q", 32'(q), 32'(m_q));
  end

  initial begin
    resetn = 1'b0; wren = 1'b0; go = 1'b0; mode = 2'b00;
    address_in = '0; data_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_cur_addr", 32'(cur_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    resetn = 1'b1;

    // Manual write/read
    address_in = 5'd3;  data_in = 4'hA; wren = 1'b1; @(negedge clock);
    address_in = 5'd31; data_in = 4'h5; @(negedge clock);
    wren = 1'b0; address_in = 5'd3; @(negedge clock);
    chk("rd_addr3", 32'(q), 32'hA);
    address_in = 5'd31; @(negedge clock);
    chk("rd_addr31", 32'(q), 32'h5);
    chk("rd_cur31", 32'(cur_addr), 32'd31);

    // Read-during-write
    address_in = 5'd7; data_in = 4'h2; wren = 1'b1; @(negedge clock);
    data_in = 4'h9; @(negedge clock);
    chk("rdw_old", 32'(q), 32'h2);
    wren = 1'b0; @(negedge clock);
    chk("rdw_new", 32'(q), 32'h9);

    // Clear walk with wren noise
    mode = 2'b01; go = 1'b1; address_in = 5'd5; data_in = 4'hF; @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      chk("clr_busy", 32'(busy), 32'h1);
      chk("clr_no_done", 32'(done), 32'h0);
      wren = (i < 31) ? i[0] : 1'b0;
      @(negedge clock);
    end
    chk("clr_end_busy", 32'(busy), 32'h0);
    chk("clr_done", 32'(done), 32'h1);
    chk("clr_wrap", 32'(cur_addr), 32'h0);
    @(negedge clock);
    chk("clr_done_pulse", 32'(done), 32'h0);
    go = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      address_in = AW'(a); @(negedge clock);
      chk("clr_read", 32'(q), 32'h0);
    end

    // Fill with 0xC
    mode = 2'b11; data_in = 4'hC; go = 1'b1; @(negedge clock);
    repeat (32) @(negedge clock);
    chk("fill_done", 32'(done), 32'h1);
    go = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      address_in = AW'(a); @(negedge clock);
      chk("fill_read", 32'(q), 32'hC);
    end

    // Fill with 0x6 aborted by reset after ten writes
    data_in = 4'h6; go = 1'b1; @(negedge clock);
    repeat (10) @(negedge clock);
    resetn = 1'b0; go = 1'b0; #1;
    chk("abort_busy", 32'(busy), 32'h0);
    @(negedge clock);
    chk("abort_cur", 32'(cur_addr), 32'h0);
    resetn = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      address_in = AW'(a); @(negedge clock);
      chk("abort_read", 32'(q), (a < 10) ? 32'h6 : 32'hC);
    end

    // Scan over mem[i] = i[3:0]
    mode = 2'b00; wren = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      address_in = AW'(a); data_in = DW'(a); @(negedge clock);
    end
    wren = 1'b0; mode = 2'b10; go = 1'b1; @(negedge clock);
    for (int k = 0; k < 33 * DWELL; k++) begin
      chk("scan_cur", 32'(cur_addr), 32'((k / DWELL) % DEPTH));
      if (k >= 1) chk("scan_q", 32'(q), 32'(((k - 1) / DWELL) % 16));
      chk("scan_busy", 32'(busy), 32'h1);
      @(negedge clock);
    end
    go = 1'b0; @(negedge clock);
    chk("scan_still_busy", 32'(busy), 32'h1);
    go = 1'b1; @(negedge clock);
    chk("scan_exit", 32'(busy), 32'h0);
    go = 1'b0; address_in = 5'd12; @(negedge clock);
    chk("post_scan_read", 32'(q), 32'hC);
    chk("post_scan_cur", 32'(cur_addr), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_scan_controller.md
# ram_scan_controller

Parametrised single-port synchronous RAM with a small control engine for the board-level lab tops. It keeps the manual read/write behaviour of the fixed 32x4 memory and adds auto-sequenced modes: clear, fill-with-value, and a timed scan that steps through every address for display. The engine does not decode hex digits. A lab top feeds `q` and `cur_addr` to the existing `hex_display` instances and drives the inputs from `SW`/`KEY`.

## Interface
- `DATA_W`, default 4: word width in bits.
- `ADDR_W`, default 5: address width. Depth = 2**ADDR_W.
- `DWELL`, default 25_000_000: clock cycles each address is held in scan mode. Must be ≥1.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `address_in`  in  ADDR_W  manual-mode address.
- `data_in`  in  DATA_W  manual write data; also the fill value.
- `wren`  in  1  level write enable, manual mode only.
- `mode`  in  2  00 manual, 01 clear, 10 scan, 11 fill. Sampled only on a `go` rising edge.
- `go`  in  1  level request from a debounced key. The block edge-detects it internally.
- `q`  out  DATA_W  registered read data.
- `cur_addr`  out  ADDR_W  address currently accessed (registered).
- `busy`  out  1  high in WALK or SCAN.
- `done`  out  1  single-cycle pulse when WALK completes.

## Operation
- **Reset:** `resetn`=0 forces state IDLE, `q`=0, `cur_addr`=0, `busy`=0, `done`=0, the walk/dwell counters to 0 and the go-edge register to 0.
  - Memory contents are not reset.
  - Reset asserted mid-WALK or mid-SCAN aborts immediately. Words already written stay written.
- **go edge:** `go_rise` = `go` & ~`go_q`. `go_q` is a register of `go`.
- **IDLE (manual):**
  - `cur_addr` <= `address_in`.
  - If `wren`, mem[`address_in`] <= `data_in`.
  - `q` <= mem[`address_in`] (read-old).
  - On `go_rise`:
    - `mode` 00: no effect.
    - `mode` 01 or 11: latch fill value (0 for 01, `data_in` for 11), set `cur_addr` <= 0, go to WALK.
    - `mode` 10: set `cur_addr` <= 0, clear the dwell counter, go to SCAN.
- **WALK:**
  - Each cycle, mem[`cur_addr`] <= latched fill value and `cur_addr` increments.
  - After writing address 2**ADDR_W−1, return to IDLE and pulse `done` in the first IDLE cycle.
  - `wren`, `go`, `mode`, `address_in` are ignored.
  - `q` holds its last value.
- **SCAN:**
  - `q` <= mem[`cur_addr`] every cycle.
  - The dwell counter counts 0..DWELL−1. At DWELL−1 it clears and `cur_addr` increments, wrapping from 2**ADDR_W−1 to 0.
  - `go_rise` returns to IDLE. The next cycle resumes manual behaviour.
  - `wren` is ignored.
- **Arithmetic:**
  - `cur_addr` increment is modulo 2**ADDR_W.
  - The dwell counter width is $clog2(DWELL+1).
  - No writes occur outside the listed cases.

## Timing
- Manual read latency is 1 cycle: `address_in` at edge N gives `q` at edge N+1.
- Read-during-write to the same address returns old data. The new data appears one cycle later.
- WALK takes exactly 2**ADDR_W cycles of `busy`=1. `done` is high in cycle 2**ADDR_W+1 after the go edge.
- SCAN: `q` reflects `cur_addr` with 1-cycle latency. Each address is held DWELL cycles.
- `go` held high never retriggers. A new rising edge is required.
- `go_rise` in the same cycle a WALK ends is ignored.

## Structure
- Package `ram_scan_pkg`:
  - state enum IDLE/WALK/SCAN;
  - mode constants `MODE_MANUAL`, `MODE_CLEAR`, `MODE_SCAN`, `MODE_FILL`.
- Sub-module `ram_sp`:
  - parametrised DATA_W/ADDR_W single-port synchronous RAM;
  - registered read-old output;
  - no reset on the array.
- The controller FSM, counters and go-edge detection live in `ram_scan_controller`.

## Test plan
Bench uses DATA_W=4, ADDR_W=5, DWELL=4.
- **Reset:** drive `resetn` low with outputs in arbitrary state → `q`=0, `cur_addr`=0, `busy`=0, `done`=0.
- **Manual write/read:** write 0xA at address 3, then 0x5 at address 31; read both → `q`=0xA and 0x5, each one cycle after the address.
- **Read-during-write:** with mem[7]=0x2, hold `address_in`=7, `wren`=1, `data_in`=0x9 → `q` shows 0x2, then 0x9.
- **Clear:** `mode`=01 with a go edge → `busy` high 32 cycles, then a `done` pulse. Afterwards all 32 addresses read 0. `wren` pulses during the walk cause no writes.
- **Fill and reset abort:**
  - `mode`=11, `data_in`=0xC, go edge → all 32 addresses read 0xC.
  - Repeat with `resetn` low at walk cycle 10 → addresses 0–9 hold the new value, 10–31 are unchanged, `busy`=0.
- **Scan:**
  - Preload mem[i]=i[3:0]; `mode`=10, go edge → `cur_addr` steps 0,1,…,31,0, each held 4 cycles, and `q` follows one cycle later.
  - `go` held high does not stop the scan. A second go edge returns to IDLE.
